// File: rtl/tdm_demux_rx.sv
// Receive side of the TDM mux path: rebuilds per-channel words from a framed,
// time-multiplexed stream and publishes each complete frame atomically.
module tdm_demux_rx #(
  parameter int WIDTH    = 2,
  parameter int CHANNELS = 2,
  parameter int CHAN_W   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          din,
  input  logic                      din_valid,
  input  logic                      fs,
  output logic [CHANNELS*WIDTH-1:0] ch_data,
  output logic                      frame_valid,
  output logic [CHAN_W-1:0]         ch_sel,
  output logic                      locked,
  output logic                      sync_err
);

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    RECV = 1'b1
  } state_t;

  localparam logic [CHAN_W-1:0] LAST_SEL = CHAN_W'(CHANNELS - 1);
  localparam logic [CHAN_W-1:0] ZERO_SEL = {CHAN_W{1'b0}};
  localparam logic [CHAN_W-1:0] ONE_SEL  = CHAN_W'(1);

  state_t                      state_r;
  state_t                      state_s;
  logic [CHAN_W-1:0]           sel_s;
  logic [CHANNELS*WIDTH-1:0]   stage_r;
  logic [CHANNELS*WIDTH-1:0]   stage_s;
  logic [CHANNELS*WIDTH-1:0]   data_s;
  logic                        fv_s;
  logic                        se_s;

  // Next-state, staging and publish decisions for the beat presented this cycle
  always_comb begin
    state_s = state_r;
    sel_s   = ch_sel;
    stage_s = stage_r;
    data_s  = ch_data;
    fv_s    = 1'b0;
    se_s    = 1'b0;
    if (din_valid) begin
      case (state_r)
        HUNT: begin
          if (fs) begin
            stage_s[WIDTH-1:0] = din;
            sel_s              = ONE_SEL;
            state_s            = RECV;
          end else begin
            sel_s = ZERO_SEL;
          end
        end
        RECV: begin
          if (fs) begin
            // A sync beat anywhere but slot 0 means the previous frame was short
            se_s               = (ch_sel != ZERO_SEL);
            stage_s[WIDTH-1:0] = din;
            sel_s              = ONE_SEL;
          end else if (ch_sel == ZERO_SEL) begin
            se_s    = 1'b1;
            sel_s   = ZERO_SEL;
            state_s = HUNT;
          end else if (ch_sel == LAST_SEL) begin
            // The last word bypasses staging so the frame publishes in one edge
            data_s = stage_r;
            data_s[(CHANNELS-1)*WIDTH +: WIDTH] = din;
            fv_s   = 1'b1;
            sel_s  = ZERO_SEL;
          end else begin
            stage_s[int'(ch_sel)*WIDTH +: WIDTH] = din;
            sel_s = ch_sel + ONE_SEL;
          end
        end
        default: begin
          state_s = HUNT;
          sel_s   = ZERO_SEL;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State, staging buffer and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= HUNT;
      stage_r     <= {(CHANNELS*WIDTH){1'b0}};
      ch_data     <= {(CHANNELS*WIDTH){1'b0}};
      ch_sel      <= ZERO_SEL;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      locked      <= 1'b0;
    end else begin
      state_r     <= state_s;
      stage_r     <= stage_s;
      ch_data     <= data_s;
      ch_sel      <= sel_s;
      frame_valid <= fv_s;
      sync_err    <= se_s;
      locked      <= (state_s == RECV);
    end
  end

endmodule

// File: tb/tb_tdm_demux_rx.sv
// Scoreboard bench: a 2-channel and a 4-channel receiver share one random/directed
// stream; a word-list model predicts per-cycle status and published frames.
module tb_tdm_demux_rx;

  typedef struct packed {
    logic       lk;
    logic [1:0] sel;
    logic       fv;
    logic       se;
    logic [7:0] data;
  } st_t;

  logic       clk;
  logic       rst;
  logic [1:0] din;
  logic       din_valid;
  logic       fs;

  logic [3:0] ch_data2;
  logic       fv2, lk2, se2;
  logic [0:0] sel2;
  logic [7:0] ch_data4;
  logic       fv4, lk4, se4;
  logic [1:0] sel4;

  int vectors = 0;
  int miscompares = 0;

  st_t        sq0[$];
  st_t        sq1[$];
  logic [7:0] fq0[$];
  logic [7:0] fq1[$];

  int         cnt[2];
  bit         lkm[2];
  logic [1:0] wb[2][16];
  logic [7:0] pub[2];

  tdm_demux_rx #(.WIDTH(2), .CHANNELS(2), .CHAN_W(1)) u2 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .fs(fs),
    .ch_data(ch_data2), .frame_valid(fv2), .ch_sel(sel2), .locked(lk2), .sync_err(se2)
  );

  tdm_demux_rx #(.WIDTH(2), .CHANNELS(4), .CHAN_W(2)) u4 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .fs(fs),
    .ch_data(ch_data4), .frame_valid(fv4), .ch_sel(sel4), .locked(lk4), .sync_err(se4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the receiver holds a list of words collected since the last sync
  task automatic model(input int i);
    st_t s;
    int  n;
    n = (i == 0) ? 2 : 4;
    s.fv = 1'b0;
    s.se = 1'b0;
    if (rst) begin
      cnt[i] = 0;
      lkm[i] = 1'b0;
      pub[i] = 8'h00;
    end else if (din_valid) begin
      if (!lkm[i]) begin
        if (fs) begin
          wb[i][0] = din;
          cnt[i]   = 1;
          lkm[i]   = 1'b1;
        end
      end else if (fs) begin
        if (cnt[i] != 0) s.se = 1'b1;
        wb[i][0] = din;
        cnt[i]   = 1;
      end else if (cnt[i] == 0) begin
        s.se   = 1'b1;
        lkm[i] = 1'b0;
      end else begin
        wb[i][cnt[i]] = din;
        cnt[i] = cnt[i] + 1;
        if (cnt[i] == n) begin
          for (int k = 0; k < n; k++) pub[i][k*2 +: 2] = wb[i][k];
          s.fv   = 1'b1;
          cnt[i] = 0;
          if (i == 0) fq0.push_back(pub[i]);
          else        fq1.push_back(pub[i]);
        end
      end
    end
    s.lk   = lkm[i];
    s.sel  = lkm[i] ? 2'(cnt[i]) : 2'd0;
    s.data = pub[i];
    if (i == 0) sq0.push_back(s);
    else        sq1.push_back(s);
  endtask

  task automatic step();
    model(0);
    model(1);
  endtask

  task automatic cyc(input bit v, input bit f, input logic [1:0] d);
    @(negedge clk);
    din_valid = v;
    fs        = f;
    din       = d;
    step();
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) cyc(1'b0, 1'($urandom), 2'($urandom));
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    #1;
    rst       = 1'b1;
    din_valid = 1'b0;
    fs        = 1'b0;
    #1;
    vectors++;
    if ({ch_data2, fv2, sel2, lk2, se2, ch_data4, fv4, sel4, lk4, se4} !== 20'h0) begin
      miscompares++;
      $display("FAIL async_reset: got d2=%h fv2=%b sel2=%0d lk2=%b se2=%b d4=%h fv4=%b sel4=%0d lk4=%b se4=%b, expected all 0",
               ch_data2, fv2, sel2, lk2, se2, ch_data4, fv4, sel4, lk4, se4);
    end
    step();
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      step();
    end
    @(negedge clk);
    rst       = 1'b0;
    din_valid = 1'b0;
    step();
  endtask

  task automatic chk(input int i);
    st_t        e;
    st_t        a;
    logic [7:0] ef;
    if (i == 0) begin
      if (sq0.size() == 0) return;
      e = sq0.pop_front();
      a = '{lk: lk2, sel: {1'b0, sel2}, fv: fv2, se: se2, data: {4'h0, ch_data2}};
    end else begin
      if (sq1.size() == 0) return;
      e = sq1.pop_front();
      a = '{lk: lk4, sel: sel4, fv: fv4, se: se4, data: ch_data4};
    end
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL status_ch%0d t=%0t: got lk=%b sel=%0d fv=%b se=%b data=%h, expected lk=%b sel=%0d fv=%b se=%b data=%h",
               (i == 0) ? 2 : 4, $time, a.lk, a.sel, a.fv, a.se, a.data, e.lk, e.sel, e.fv, e.se, e.data);
    end
    if (a.fv === 1'b1) begin
      vectors++;
      if ((i == 0 && fq0.size() == 0) || (i == 1 && fq1.size() == 0)) begin
        miscompares++;
        $display("FAIL frame_ch%0d t=%0t: got unexpected frame %h, expected none", (i == 0) ? 2 : 4, $time, a.data);
      end else begin
        ef = (i == 0) ? fq0.pop_front() : fq1.pop_front();
        if (a.data !== ef) begin
          miscompares++;
          $display("FAIL frame_ch%0d t=%0t: got %h, expected %h", (i == 0) ? 2 : 4, $time, a.data, ef);
        end
      end
    end
  endtask

  // Monitor: after every active edge, pop and compare what each receiver presents
  initial begin
    forever begin
      @(posedge clk);
      #2;
      chk(0);
      chk(1);
    end
  end

  initial begin
    rst       = 1'b1;
    din_valid = 1'b0;
    fs        = 1'b0;
    din       = 2'b00;
    do_reset(2);

    cyc(1'b1, 1'b1, 2'd1); cyc(1'b1, 1'b0, 2'd2); idle(2);

    cyc(1'b1, 1'b1, 2'd3); cyc(1'b1, 1'b0, 2'd0);
    cyc(1'b1, 1'b1, 2'd1); cyc(1'b1, 1'b0, 2'd2);
    cyc(1'b1, 1'b1, 2'd2); cyc(1'b1, 1'b0, 2'd1);
    idle(1);

    // Missing sync after a full frame, then unsynchronised beats while hunting
    cyc(1'b1, 1'b0, 2'd1);
    cyc(1'b1, 1'b0, 2'd0); cyc(1'b1, 1'b0, 2'd2); cyc(1'b1, 1'b0, 2'd3);
    cyc(1'b1, 1'b1, 2'd1); cyc(1'b1, 1'b0, 2'd3); idle(2);

    do_reset(1);
    cyc(1'b1, 1'b1, 2'd2); cyc(1'b1, 1'b0, 2'd1);
    cyc(1'b1, 1'b1, 2'd3); cyc(1'b1, 1'b0, 2'd0); cyc(1'b1, 1'b0, 2'd1); cyc(1'b1, 1'b0, 2'd2);
    idle(2);

    cyc(1'b1, 1'b1, 2'd1); idle(5); cyc(1'b1, 1'b0, 2'd2); idle(5);
    cyc(1'b1, 1'b0, 2'd3); cyc(1'b1, 1'b0, 2'd1); idle(2);

    cyc(1'b1, 1'b1, 2'd3); do_reset(1); cyc(1'b1, 1'b0, 2'd1); idle(3);

    for (int j = 0; j < 800; j++) begin
      if ($urandom_range(0, 299) == 0) do_reset(1);
      cyc($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0, 2'($urandom));
    end
    idle(2);
    @(negedge clk);
    @(negedge clk);

    vectors++;
    if (sq0.size() + sq1.size() + fq0.size() + fq1.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d/%0d status and %0d/%0d frames outstanding, expected 0",
               sq0.size(), sq1.size(), fq0.size(), fq1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
